pe_window_addr_gen: RTL and testbench

- Parametrised successor to the single-counter PE address controller. It generates input-feature-map read addresses for a KxK convolution window sliding over an H x W x C feature map with configurable stride.
- Address advance is gated by en and valid, as in the existing controller. Adds start/done sequencing, per-window first/last markers and a wrap-free end of frame.
- Sits between the fused-block scheduler and the IFM buffer read port, and drives the PE array's accumulate control.

---
 rtl/pe_window_addr_gen.sv | 195 +++++++++++++++++++
 tb/tb_pe_window_addr_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_window_addr_gen.sv
// Sliding KxK window read-address generator for an HWC feature map.
// Walks c, kx, ky, ox, oy (innermost first) on each accepted address and
// emits one frame per start, with per-window first/last markers and a done pulse.
module pe_window_addr_gen #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned IFM_W  = 8,
   parameter int unsigned IFM_H  = 8,
   parameter int unsigned CH     = 2,
   parameter int unsigned K      = 3,
   parameter int unsigned STRIDE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              start,
   input  logic              en,
   input  logic              valid,
   output logic [ADDR_W-1:0] addr,
   output logic              addr_valid,
   output logic              win_first,
   output logic              win_last,
   output logic              busy,
   output logic              done
);

   localparam int unsigned OW = (IFM_W - K) / STRIDE + 1;
   localparam int unsigned OH = (IFM_H - K) / STRIDE + 1;
   localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;
   localparam int unsigned KW = (K  > 1) ? $clog2(K)  : 1;
   localparam int unsigned XW = (OW > 1) ? $clog2(OW) : 1;
   localparam int unsigned YW = (OH > 1) ? $clog2(OH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CW-1:0]     c_q, c_d;
   logic [KW-1:0]     kx_q, kx_d, ky_q, ky_d;
   logic [XW-1:0]     ox_q, ox_d;
   logic [YW-1:0]     oy_q, oy_d;
   logic [ADDR_W-1:0] addr_d;
   logic              addr_valid_d, win_first_d, win_last_d, busy_d, done_d;

   logic c_last, kx_last, ky_last, ox_last, oy_last, frame_last;

   // Full address from window position and in-window offset, modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] calc_addr(
      input logic [ADDR_W-1:0] base,
      input logic [YW-1:0]     oy,
      input logic [XW-1:0]     ox,
      input logic [KW-1:0]     ky,
      input logic [KW-1:0]     kx,
      input logic [CW-1:0]     c
   );
      logic [ADDR_W-1:0] row;
      logic [ADDR_W-1:0] col;
      row = ADDR_W'(oy) * ADDR_W'(STRIDE) + ADDR_W'(ky);
      col = ADDR_W'(ox) * ADDR_W'(STRIDE) + ADDR_W'(kx);
      return base + (row * ADDR_W'(IFM_W) + col) * ADDR_W'(CH) + ADDR_W'(c);
   endfunction

   // Terminal-count detection for each counter.
   always_comb begin
      c_last     = (c_q  == CW'(CH - 1));
      kx_last    = (kx_q == KW'(K - 1));
      ky_last    = (ky_q == KW'(K - 1));
      ox_last    = (ox_q == XW'(OW - 1));
      oy_last    = (oy_q == YW'(OH - 1));
      frame_last = c_last & kx_last & ky_last & ox_last & oy_last;
   end

   // Next-state, counter and output logic.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      c_d          = c_q;
      kx_d         = kx_q;
      ky_d         = ky_q;
      ox_d         = ox_q;
      oy_d         = oy_q;
      addr_d       = addr;
      addr_valid_d = addr_valid;
      win_first_d  = win_first;
      win_last_d   = win_last;
      busy_d       = busy;
      done_d       = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start && en) begin
               state_d      = RUN;
               base_d       = base_addr;
               c_d          = '0;
               kx_d         = '0;
               ky_d         = '0;
               ox_d         = '0;
               oy_d         = '0;
               addr_d       = base_addr;
               addr_valid_d = 1'b1;
               win_first_d  = 1'b1;
               win_last_d   = (CH == 1) && (K == 1);
               busy_d       = 1'b1;
            end
         end

         RUN: begin
            if (en && valid) begin
               if (frame_last) begin
                  state_d      = DONE;
                  addr_valid_d = 1'b0;
                  win_first_d  = 1'b0;
                  win_last_d   = 1'b0;
                  done_d       = 1'b1;
               end else begin
                  // Nested advance; the frame-end case above keeps oy from wrapping.
                  if (!c_last) begin
                     c_d = c_q + CW'(1);
                  end else begin
                     c_d = '0;
                     if (!kx_last) begin
                        kx_d = kx_q + KW'(1);
                     end else begin
                        kx_d = '0;
                        if (!ky_last) begin
                           ky_d = ky_q + KW'(1);
                        end else begin
                           ky_d = '0;
                           if (!ox_last) begin
                              ox_d = ox_q + XW'(1);
                           end else begin
                              ox_d = '0;
                              oy_d = oy_q + YW'(1);
                           end
                        end
                     end
                  end
                  addr_d       = calc_addr(base_q, oy_d, ox_d, ky_d, kx_d, c_d);
                  addr_valid_d = 1'b1;
                  win_first_d  = (c_d == '0) && (kx_d == '0) && (ky_d == '0);
                  win_last_d   = (c_d == CW'(CH - 1)) && (kx_d == KW'(K - 1)) &&
                                 (ky_d == KW'(K - 1));
               end
            end
         end

         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         base_q     <= '0;
         c_q        <= '0;
         kx_q       <= '0;
         ky_q       <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         addr       <= '0;
         addr_valid <= 1'b0;
         win_first  <= 1'b0;
         win_last   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         c_q        <= c_d;
         kx_q       <= kx_d;
         ky_q       <= ky_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         addr       <= addr_d;
         addr_valid <= addr_valid_d;
         win_first  <= win_first_d;
         win_last   <= win_last_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

endmodule

// File: tb/tb_pe_window_addr_gen.sv
// Directed bench for pe_window_addr_gen: default geometry and a stride-2 instance.
module tb_pe_window_addr_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start1 = 1'b0;
   logic        start2 = 1'b0;
   logic        en = 1'b0;
   logic        valid = 1'b0;
   logic [19:0] base_addr = '0;

   logic [19:0] addr1, addr2;
   logic        av1, av2, wf1, wf2, wl1, wl2, busy1, busy2, done1, done2;

   int n_assert = 0;
   int n_fail   = 0;
   logic sel = 1'b0;

   logic        vseq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [19:0] eseq [6] = '{20'h00101, 20'h00101, 20'h00101,
                             20'h00102, 20'h00103, 20'h00103};

   wire [19:0] m_addr = sel ? addr2 : addr1;
   wire        m_av   = sel ? av2   : av1;
   wire        m_wf   = sel ? wf2   : wf1;
   wire        m_wl   = sel ? wl2   : wl1;
   wire        m_busy = sel ? busy2 : busy1;
   wire        m_done = sel ? done2 : done1;

   always #5 clk = ~clk;

   pe_window_addr_gen dut1 (
      .clk(clk), .reset(reset), .base_addr(base_addr), .start(start1),
      .en(en), .valid(valid), .addr(addr1), .addr_valid(av1),
      .win_first(wf1), .win_last(wl1), .busy(busy1), .done(done1)
   );

   pe_window_addr_gen #(.STRIDE(2)) dut2 (
      .clk(clk), .reset(reset), .base_addr(base_addr), .start(start2),
      .en(en), .valid(valid), .addr(addr2), .addr_valid(av2),
      .win_first(wf2), .win_last(wl2), .busy(busy2), .done(done2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference address for element idx of an 8x8x2 frame with K=3.
   function automatic logic [19:0] model_addr(input logic [19:0] base, input int idx, input int s);
      int c, kx, ky, w, ow, ox, oy;
      c  = idx % 2;
      kx = (idx / 2) % 3;
      ky = (idx / 6) % 3;
      w  = idx / 18;
      ow = (8 - 3) / s + 1;
      ox = w % ow;
      oy = w / ow;
      return base + 20'(((oy * s + ky) * 8 + ox * s + kx) * 2 + c);
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_addr"}, 32'(m_addr), 0);
      check({tag, "_av"},   32'(m_av),   0);
      check({tag, "_wf"},   32'(m_wf),   0);
      check({tag, "_wl"},   32'(m_wl),   0);
      check({tag, "_busy"}, 32'(m_busy), 0);
      check({tag, "_done"}, 32'(m_done), 0);
   endtask

   // Full frame with valid held high; start is re-asserted at element start_at.
   task automatic run_frame(input logic s2, input logic [19:0] base, input int n_exp,
                            input int start_at, input logic [19:0] exp_last);
      int idx;
      int cyc;
      int s;
      s = s2 ? 2 : 1;
      sel = s2;
      base_addr = base;
      en = 1'b1;
      valid = 1'b1;
      if (s2) start2 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      idx = 0;
      cyc = 0;
      while (m_av === 1'b1 && cyc < 2000) begin
         check("frame_addr", 32'(m_addr), 32'(model_addr(base, idx, s)));
         check("frame_wf", 32'(m_wf), 32'((idx % 18) == 0));
         check("frame_wl", 32'(m_wl), 32'((idx % 18) == 17));
         check("frame_busy", 32'(m_busy), 1);
         check("frame_nodone", 32'(m_done), 0);
         if (idx == start_at) begin
            if (s2) start2 = 1'b1; else start1 = 1'b1;
         end else begin
            start1 = 1'b0;
            start2 = 1'b0;
         end
         idx++;
         cyc++;
         @(negedge clk);
      end
      start1 = 1'b0;
      start2 = 1'b0;
      check("accepts", 32'(idx), 32'(n_exp));
      check("done_pulse", 32'(m_done), 1);
      check("done_busy", 32'(m_busy), 1);
      check("done_av", 32'(m_av), 0);
      check("done_wf", 32'(m_wf), 0);
      check("done_wl", 32'(m_wl), 0);
      check("last_addr", 32'(m_addr), 32'(exp_last));
      // start during the DONE cycle must be ignored
      if (s2) start2 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      check("post_done", 32'(m_done), 0);
      check("post_busy", 32'(m_busy), 0);
      check("post_av", 32'(m_av), 0);
      @(negedge clk);
      check("still_idle", 32'(m_busy), 0);
   endtask

   initial begin
      // Reset held for two cycles, with start asserted to show reset wins.
      reset = 1'b1;
      start1 = 1'b1;
      en = 1'b1;
      repeat (2) @(negedge clk);
      sel = 1'b0;
      check_idle("reset1");
      sel = 1'b1;
      check_idle("reset2");
      sel = 1'b0;
      reset = 1'b0;
      start1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_busy", 32'(busy1), 0);
         check("idle_av", 32'(av1), 0);
      end

      // Valid gating from frame start.
      base_addr = 20'h00100;
      valid = 1'b0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("first_addr", 32'(addr1), 32'h100);
      check("first_av", 32'(av1), 1);
      check("first_wf", 32'(wf1), 1);
      check("first_busy", 32'(busy1), 1);
      for (int i = 0; i < 6; i++) begin
         valid = vseq[i];
         @(negedge clk);
         check("gate_addr", 32'(addr1), 32'(eseq[i]));
      end

      // en low freezes everything even with valid high.
      valid = 1'b1;
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("freeze_addr", 32'(addr1), 32'h103);
         check("freeze_av", 32'(av1), 1);
         check("freeze_done", 32'(done1), 0);
      end
      en = 1'b1;
      valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle("abandon");

      // Reset after 100 accepts, then restart at base.
      valid = 1'b1;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (100) @(negedge clk);
      check("pre_reset_addr", 32'(addr1), 32'(model_addr(20'h00100, 100, 1)));
      reset = 1'b1;
      start1 = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start1 = 1'b0;
      check_idle("midreset");
      @(negedge clk);
      check("midreset_nodone", 32'(done1), 0);
      check("midreset_busy", 32'(busy1), 0);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("restart_addr", 32'(addr1), 32'h100);
      check("restart_wf", 32'(wf1), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Complete frames.
      run_frame(1'b0, 20'h00100, 648, -1, 20'h0017F);
      run_frame(1'b0, 20'hFFFF0, 648, -1, 20'h0006F);
      run_frame(1'b1, 20'h00200, 162, 50, 20'h0026D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
